// File: rtl/hazard_unit_sb.sv
// rtl/hazard_unit_sb.sv - pipeline hazard/forwarding unit with long-latency scoreboard
module hazard_unit_sb #(
    parameter int REG_AW       = 5,
    parameter int NUM_RD_PORTS = 2,
    parameter int LONG_LAT     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   src_iss_hz_i,
    input  logic [NUM_RD_PORTS-1:0]          src_vld_iss_hz_i,
    input  logic [REG_AW-1:0]                rd_iss_hz_i,
    input  logic                             reg_wr_iss_hz_i,
    input  logic                             long_op_iss_hz_i,
    input  logic                             iss_vld_hz_i,
    input  logic                             jump_iss_hz_i,
    input  logic [NUM_RD_PORTS*REG_AW-1:0]   src_ex_hz_i,
    input  logic [REG_AW-1:0]                rd_ex_hz_i,
    input  logic                             mem_to_reg_ex_hz_i,
    input  logic [REG_AW-1:0]                rd_mem_hz_i,
    input  logic                             reg_wr_mem_hz_i,
    input  logic [REG_AW-1:0]                rd_wb_hz_i,
    input  logic                             reg_wr_wb_hz_i,
    input  logic                             branch_taken_ex_hz_i,
    input  logic                             brn_pred_ex_hz_i,
    output logic                             stall_fetch_hz_o,
    output logic                             stall_iss_hz_o,
    output logic                             flush_iss_hz_o,
    output logic                             flush_ex_hz_o,
    output logic [2*NUM_RD_PORTS-1:0]        fwd_ex_hz_o,
    output logic                             long_busy_hz_o,
    output logic                             long_wb_hz_o,
    output logic [REG_AW-1:0]                long_rd_hz_o
);

    localparam int NREG = 1 << REG_AW;

    logic [NREG-1:0]   pending;
    logic [3:0]        cnt;
    logic [REG_AW-1:0] long_rd;
    logic              mispred;
    logic              busy;
    logic              load_use;
    logic              raw_pend;
    logic              waw_pend;
    logic              struct_hz;
    logic              raw_stall;
    logic              accept;

    assign mispred = branch_taken_ex_hz_i & ~brn_pred_ex_hz_i;
    assign busy    = (cnt != 4'd0);

    always_comb begin
        load_use = 1'b0;
        raw_pend = 1'b0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (src_vld_iss_hz_i[p]) begin
                if (rd_ex_hz_i == src_iss_hz_i[p*REG_AW +: REG_AW])
                    load_use = 1'b1;
                if (pending[src_iss_hz_i[p*REG_AW +: REG_AW]])
                    raw_pend = 1'b1;
            end
        end
        load_use = load_use & mem_to_reg_ex_hz_i & (rd_ex_hz_i != '0);
    end

    assign waw_pend  = reg_wr_iss_hz_i & pending[rd_iss_hz_i];
    assign struct_hz = long_op_iss_hz_i & busy;
    assign raw_stall = iss_vld_hz_i & (load_use | raw_pend | waw_pend | struct_hz);

    // A mispredict squashes the issue slot, so nothing there needs holding.
    assign stall_iss_hz_o   = raw_stall & ~mispred;
    assign stall_fetch_hz_o = stall_iss_hz_o;
    assign flush_ex_hz_o    = mispred;
    assign flush_iss_hz_o   = mispred | (jump_iss_hz_i & ~stall_iss_hz_o);

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_fwd
        logic [REG_AW-1:0] src;
        assign src = src_ex_hz_i[p*REG_AW +: REG_AW];
        assign fwd_ex_hz_o[2*p +: 2] =
            (reg_wr_mem_hz_i && rd_mem_hz_i != '0 && rd_mem_hz_i == src) ? 2'b10 :
            (reg_wr_wb_hz_i  && rd_wb_hz_i  != '0 && rd_wb_hz_i  == src) ? 2'b01 :
                                                                           2'b00;
    end

    assign accept = iss_vld_hz_i & long_op_iss_hz_i & ~stall_iss_hz_o & ~mispred;

    // Acceptance needs cnt == 0 and clearing happens at cnt == 1, so set/clear never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 4'd0;
            pending <= '0;
            long_rd <= '0;
        end else begin
            if (accept)
                cnt <= 4'(LONG_LAT);
            else if (busy)
                cnt <= cnt - 4'd1;

            if (long_wb_hz_o)
                pending[long_rd] <= 1'b0;
            if (accept && reg_wr_iss_hz_i && rd_iss_hz_i != '0) begin
                pending[rd_iss_hz_i] <= 1'b1;
                long_rd              <= rd_iss_hz_i;
            end
        end
    end

    assign long_busy_hz_o = busy;
    assign long_wb_hz_o   = (cnt == 4'd1);
    assign long_rd_hz_o   = long_rd;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// tb/tb_hazard_unit_sb.sv - directed self-checking bench for hazard_unit_sb
module tb_hazard_unit_sb;

    localparam int REG_AW = 5;
    localparam int NP     = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*REG_AW-1:0] src_iss, src_ex;
    logic [NP-1:0]     src_vld;
    logic [REG_AW-1:0] rd_iss, rd_ex, rd_mem, rd_wb;
    logic              reg_wr_iss, long_op, iss_vld, jump, mem_to_reg;
    logic              reg_wr_mem, reg_wr_wb, br_taken, br_pred;
    logic              stall_fetch, stall_iss, flush_iss, flush_ex;
    logic [2*NP-1:0]   fwd;
    logic              busy, long_wb;
    logic [REG_AW-1:0] long_rd;

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit_sb #(.REG_AW(REG_AW), .NUM_RD_PORTS(NP), .LONG_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .src_iss_hz_i(src_iss), .src_vld_iss_hz_i(src_vld), .rd_iss_hz_i(rd_iss),
        .reg_wr_iss_hz_i(reg_wr_iss), .long_op_iss_hz_i(long_op), .iss_vld_hz_i(iss_vld),
        .jump_iss_hz_i(jump), .src_ex_hz_i(src_ex), .rd_ex_hz_i(rd_ex),
        .mem_to_reg_ex_hz_i(mem_to_reg), .rd_mem_hz_i(rd_mem), .reg_wr_mem_hz_i(reg_wr_mem),
        .rd_wb_hz_i(rd_wb), .reg_wr_wb_hz_i(reg_wr_wb), .branch_taken_ex_hz_i(br_taken),
        .brn_pred_ex_hz_i(br_pred), .stall_fetch_hz_o(stall_fetch), .stall_iss_hz_o(stall_iss),
        .flush_iss_hz_o(flush_iss), .flush_ex_hz_o(flush_ex), .fwd_ex_hz_o(fwd),
        .long_busy_hz_o(busy), .long_wb_hz_o(long_wb), .long_rd_hz_o(long_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        src_iss = '0; src_vld = '0; rd_iss = '0; reg_wr_iss = 0; long_op = 0;
        iss_vld = 0; jump = 0; src_ex = '0; rd_ex = '0; mem_to_reg = 0;
        rd_mem = '0; reg_wr_mem = 0; rd_wb = '0; reg_wr_wb = 0;
        br_taken = 0; br_pred = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an instruction reading src0 only.
    task automatic issue_src0(input logic [REG_AW-1:0] s);
        iss_vld = 1; src_iss = {5'd0, s}; src_vld = 2'b01;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        chk("rst_stall", stall_iss, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb", long_wb, 0);
        chk("rst_fwd", fwd, 0);
        reset = 0;

        // Load-use
        tick();
        mem_to_reg = 1; rd_ex = 5; issue_src0(5);
        #1;
        chk("lu_stall_iss", stall_iss, 1);
        chk("lu_stall_fetch", stall_fetch, 1);
        chk("lu_flush_iss", flush_iss, 0);
        rd_ex = 0; src_iss = '0;
        #1;
        chk("lu_rd0", stall_iss, 0);
        tick();
        idle();
        #1;
        chk("lu_released", stall_iss, 0);

        // Forwarding
        rd_mem = 3; reg_wr_mem = 1; rd_wb = 3; reg_wr_wb = 1; src_ex = {5'd3, 5'd3};
        #1;
        chk("fwd_mem_pri", fwd, 4'b1010);
        rd_mem = 7; src_ex = {5'd3, 5'd7};
        #1;
        chk("fwd_mem_wb", fwd, 4'b0110);
        reg_wr_wb = 0;
        #1;
        chk("fwd_wb_off", fwd, 4'b0010);
        rd_mem = 0; src_ex = '0;
        #1;
        chk("fwd_r0", fwd, 4'b0000);

        // Long op accepted at cycle t
        tick();
        idle();
        iss_vld = 1; long_op = 1; reg_wr_iss = 1; rd_iss = 9;
        #1;
        chk("t_stall", stall_iss, 0);
        chk("t_busy", busy, 0);
        tick();                                   // t+1
        idle(); issue_src0(9);
        #1;
        chk("t1_raw", stall_iss, 1);
        chk("t1_busy", busy, 1);
        chk("t1_wb", long_wb, 0);
        tick();                                   // t+2
        idle(); iss_vld = 1; long_op = 1; reg_wr_iss = 1; rd_iss = 10;
        #1;
        chk("t2_struct", stall_iss, 1);
        long_op = 0; rd_iss = 9;
        #1;
        chk("t2_waw", stall_iss, 1);
        rd_iss = 4; issue_src0(4);
        #1;
        chk("t2_indep", stall_iss, 0);
        tick();                                   // t+3
        idle(); issue_src0(9);
        #1;
        chk("t3_raw", stall_iss, 1);
        chk("t3_wb", long_wb, 0);
        tick();                                   // t+4
        #1;
        chk("t4_raw", stall_iss, 1);
        chk("t4_wb", long_wb, 1);
        chk("t4_rd", long_rd, 9);
        chk("t4_busy", busy, 1);
        tick();                                   // t+5
        #1;
        chk("t5_raw", stall_iss, 0);
        chk("t5_busy", busy, 0);
        chk("t5_wb", long_wb, 0);

        // Mispredict overrides load-use stall and blocks acceptance
        idle();
        mem_to_reg = 1; rd_ex = 5; issue_src0(5);
        long_op = 1; reg_wr_iss = 1; rd_iss = 12;
        #1;
        chk("mp_pre_stall", stall_iss, 1);
        br_taken = 1;
        #1;
        chk("mp_stall", stall_iss, 0);
        chk("mp_flush_ex", flush_ex, 1);
        chk("mp_flush_iss", flush_iss, 1);
        tick();
        idle(); issue_src0(12);
        #1;
        chk("mp_no_accept", busy, 0);
        chk("mp_no_pend", stall_iss, 0);
        br_taken = 1; br_pred = 1;
        #1;
        chk("pred_ok_flush", flush_ex, 0);

        // Jump while stalled
        idle();
        mem_to_reg = 1; rd_ex = 5; issue_src0(5); jump = 1;
        #1;
        chk("jmp_stalled", flush_iss, 0);
        rd_ex = 0;
        #1;
        chk("jmp_free", flush_iss, 1);

        // Long op without writeback: pulses but marks nothing pending
        tick();
        idle(); iss_vld = 1; long_op = 1; rd_iss = 6;
        tick();                                   // t+1
        idle(); issue_src0(6);
        #1;
        chk("nw_busy", busy, 1);
        chk("nw_no_pend", stall_iss, 0);
        tick(); tick(); tick();                   // t+4
        #1;
        chk("nw_wb", long_wb, 1);

        // Jump with long op still accepted, then reset mid-operation
        tick();
        idle(); iss_vld = 1; long_op = 1; reg_wr_iss = 1; rd_iss = 9; jump = 1;
        #1;
        chk("jl_flush_iss", flush_iss, 1);
        tick();                                   // t+1
        idle();
        #1;
        chk("jl_busy", busy, 1);
        tick();                                   // t+2
        reset = 1;
        tick();                                   // t+3
        reset = 0; issue_src0(9);
        #1;
        chk("rm_busy", busy, 0);
        chk("rm_pend", stall_iss, 0);
        chk("rm_wb3", long_wb, 0);
        tick();
        #1;
        chk("rm_wb4", long_wb, 0);
        tick();
        #1;
        chk("rm_wb5", long_wb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
